display_mode_ctrl: RTL and testbench
====================================

// Module: display_mode_ctrl
// PURPOSE
// - Button-driven display controller inside comp_core. Debounces the synchronised nMode/nTrip inputs.
// - Steps the display-mode register that selects which value the LED/OLED datapath shows.
// - Sequences trip-meter control: short press of Trip toggles run/pause; long press clears the trip.
// PARAMETERS
// DEBOUNCE_CYCLES    655    consecutive stable samples needed to accept a level change (20 ms @ 32768 Hz)
// LONG_PRESS_CYCLES  65536  debounced Trip hold length treated as a long press (2 s @ 32768 Hz)
// PORTS
// HCLK         in   1  core clock
// HRESETn      in   1  asynchronous active-low reset
// nMode        in   1  Mode button, active low, already synchronised to HCLK
// nTrip        in   1  Trip button, active low, already synchronised to HCLK
// mode         out  3  display select: 0 ODO, 1 TRIP_DIST, 2 TRIP_TIME, 3 SPEED, 4 CADENCE (option only)
// mode_change  out  1  one-cycle pulse when mode updates
// trip_run     out  1  1 = trip distance/time accumulate, 0 = paused
// trip_clear   out  1  one-cycle pulse: clear trip distance and time
// BEHAVIOUR
// - One clock, HCLK. HRESETn is asynchronous and active low; the reset values below apply while it is low.
// - Reset values: mode=0, mode_change=0, trip_run=0, trip_clear=0.
// - Reset values, internal: both debounced levels=1 (released), debounce counters=0, hold counter=0, trip FSM=IDLE.
// - Debouncer, one per button, identical:
//   - When raw == debounced level, the counter is 0.
//   - When raw != debounced level, the counter increments each edge.
//   - On the edge where the count reaches DEBOUNCE_CYCLES, the level flips and the counter returns to 0.
//   - A raw glitch shorter than DEBOUNCE_CYCLES edges produces no change.
// - Press = debounced 1->0; release = debounced 0->1.
// - Mode path:
//   - A Mode press updates mode on the next edge (1-cycle latency); mode_change pulses in that same cycle.
//   - mode increments and wraps from the last legal value to 0.
//   - Release has no effect. Mode is independent of Trip state, so simultaneous events are both honoured.
// - Trip FSM, states IDLE, HELD, LONG:
//   - IDLE: press -> HELD, hold counter cleared.
//   - HELD: hold counter +1 per edge.
//     - Release with count < LONG_PRESS_CYCLES -> IDLE; trip_run toggles on the next edge.
//     - Count reaching LONG_PRESS_CYCLES -> LONG; trip_clear pulses for exactly 1 cycle and trip_run is forced to 0.
//   - LONG: the hold counter is frozen, with no further pulses. Release -> IDLE with no toggle.
// - The hold counter is wide enough for LONG_PRESS_CYCLES and saturates; it never wraps.
// - trip_clear and a trip_run toggle are never both produced by one press.
// - Reset mid-press: everything returns to reset values immediately.
//   - A button still held when HRESETn releases is seen as a fresh press after DEBOUNCE_CYCLES edges.
// CONFIGURATION
// - CADENCE_MODE_EN defined:
//   - mode cycles 0..4 (adds CADENCE); wrap is 4->0.
// - CADENCE_MODE_EN undefined:
//   - mode cycles 0..3; wrap is 3->0; the value 4 is never driven.
// - The mode port is 3 bits in both builds.
// TESTING (bench parameters DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
// - nMode low 6 cycles from reset -> mode 0->1 on the edge after the 4th low sample, mode_change high 1 cycle; release gives no change.
// - nMode low 3 cycles then high -> mode stays 0, mode_change never asserts.
// - 4 valid Mode presses -> mode 1,2,3,0; with CADENCE_MODE_EN, 5 presses -> 1,2,3,4,0.
// - nTrip low 10 cycles then high -> trip_run 0->1 one edge after the debounced release, trip_clear stays 0; repeat -> trip_run 1->0.
// - trip_run=1, nTrip held 40 cycles -> a single trip_clear pulse 16 edges after the debounced press, trip_run=0; release gives no toggle.
// - HRESETn pulsed low during a Trip hold at count 10 -> outputs at reset values at once; release after reset -> no trip_clear, no toggle.

Source files
------------

// File: rtl/display_mode_ctrl.sv
// Button-driven display controller: debounces nMode/nTrip, steps the display mode and
// sequences trip run/pause/clear. Define CADENCE_MODE_EN to add the CADENCE mode (4).
module display_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES   = 655,
    parameter int unsigned LONG_PRESS_CYCLES = 65536
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       nMode,
    input  logic       nTrip,
    output logic [2:0] mode,
    output logic       mode_change,
    output logic       trip_run,
    output logic       trip_clear
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] LongCnt = HoldW'(LONG_PRESS_CYCLES);
`ifdef CADENCE_MODE_EN
    localparam logic [2:0] ModeLast = 3'd4;
`else
    localparam logic [2:0] ModeLast = 3'd3;
`endif

    typedef enum logic [1:0] {StIdle, StHeld, StLong} trip_state_e;

    // Index 0 = Mode button, index 1 = Trip button; level 1 means released.
    logic [1:0]     raw;
    logic [1:0]     lvl_q, lvl_d, prev_q;
    logic [DbW-1:0] cnt_q [2];
    logic [DbW-1:0] cnt_d [2];
    logic [1:0]     press, release_evt;

    logic [2:0]       mode_q, mode_d;
    logic             mode_change_q, mode_change_d;
    trip_state_e      state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d, hold_inc;
    logic             run_q, run_d;
    logic             clear_q, clear_d;

    assign raw = {nTrip, nMode};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = '0;
            if (raw[i] != lvl_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    lvl_d[i] = raw[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    // Events are seen one edge after the debounced level changes.
    assign press       = prev_q & ~lvl_q;
    assign release_evt = ~prev_q & lvl_q;

    always_comb begin
        mode_d        = mode_q;
        mode_change_d = 1'b0;
        if (press[0]) begin
            mode_d        = (mode_q == ModeLast) ? 3'd0 : mode_q + 3'd1;
            mode_change_d = 1'b1;
        end
    end

    assign hold_inc = hold_q + HoldW'(1);

    // Hold count includes the edge that takes the press, so it equals edges since the press.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        run_d   = run_q;
        clear_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                hold_d = '0;
                if (press[1]) begin
                    state_d = StHeld;
                    hold_d  = HoldW'(1);
                end
            end
            StHeld: begin
                if (release_evt[1]) begin
                    state_d = StIdle;
                    hold_d  = '0;
                    run_d   = ~run_q;
                end else if (hold_q != LongCnt) begin
                    hold_d = hold_inc;
                    if (hold_inc == LongCnt) begin
                        state_d = StLong;
                        clear_d = 1'b1;
                        run_d   = 1'b0;
                    end
                end
            end
            StLong: begin
                if (release_evt[1]) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lvl_q         <= 2'b11;
            prev_q        <= 2'b11;
            cnt_q[0]      <= '0;
            cnt_q[1]      <= '0;
            mode_q        <= '0;
            mode_change_q <= 1'b0;
            state_q       <= StIdle;
            hold_q        <= '0;
            run_q         <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            lvl_q         <= lvl_d;
            prev_q        <= lvl_q;
            cnt_q[0]      <= cnt_d[0];
            cnt_q[1]      <= cnt_d[1];
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            state_q       <= state_d;
            hold_q        <= hold_d;
            run_q         <= run_d;
            clear_q       <= clear_d;
        end
    end

    assign mode        = mode_q;
    assign mode_change = mode_change_q;
    assign trip_run    = run_q;
    assign trip_clear  = clear_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
module tb_display_mode_ctrl;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Long = 16;
`ifdef CADENCE_MODE_EN
    localparam int NumModes = 5;
`else
    localparam int NumModes = 4;
`endif

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       nMode = 1'b1;
    logic       nTrip = 1'b1;
    logic [2:0] mode;
    logic       mode_change;
    logic       trip_run;
    logic       trip_clear;

    int checks = 0;
    int errors = 0;

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES  (Deb),
        .LONG_PRESS_CYCLES(Long)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .nMode      (nMode),
        .nTrip      (nTrip),
        .mode       (mode),
        .mode_change(mode_change),
        .trip_run   (trip_run),
        .trip_clear (trip_clear)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic nm;
        logic nt;
        int   e_mode;
        logic e_mc;
        logic e_run;
        logic e_clr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic void add(input logic nm, input logic nt, input int em, input logic emc,
                                input logic er, input logic ec);
        vec_t v;
        v.nm = nm; v.nt = nt; v.e_mode = em; v.e_mc = emc; v.e_run = er; v.e_clr = ec;
        vecs.push_back(v);
    endfunction

    task automatic mode_press(input int exp_mode);
        int pulses = 0;
        nMode = 1'b0;
        for (int k = 0; k < 6; k++) begin tick(); if (mode_change) pulses++; end
        nMode = 1'b1;
        for (int k = 0; k < 6; k++) begin tick(); if (mode_change) pulses++; end
        chk($sformatf("mode_press pulses (to %0d)", exp_mode), pulses, 1);
        chk($sformatf("mode_press value (to %0d)", exp_mode), int'(mode), exp_mode);
    endtask

    // nTrip low 10, high 6: debounced release at tick 14, toggle visible after tick 15.
    task automatic trip_short(input logic exp_run);
        int toggle_at = -1;
        int clears = 0;
        logic start;
        start = trip_run;
        nTrip = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 11) nTrip = 1'b1;
            tick();
            if (trip_clear) clears++;
            if (toggle_at < 0 && trip_run != start) toggle_at = k;
        end
        chk("trip_short toggle tick", toggle_at, 15);
        chk("trip_short run", int'(trip_run), int'(exp_run));
        chk("trip_short no clear", clears, 0);
    endtask

    initial begin
        int clears;
        int clear_at;
        int run_changes;

        // Mode press: low 6 then released
        for (int k = 1; k <= 6; k++) add(1'b0, 1'b1, (k >= 5) ? 1 : 0, (k == 5), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) add(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        // Glitch of 3 samples
        for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) add(1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        // Trip short press: low 10 then high 6
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        for (int k = 11; k <= 16; k++) add(1'b1, 1'b1, 1, 1'b0, (k >= 15), 1'b0);

        #12;
        chk("reset mode", int'(mode), 0);
        chk("reset mode_change", int'(mode_change), 0);
        chk("reset trip_run", int'(trip_run), 0);
        chk("reset trip_clear", int'(trip_clear), 0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        foreach (vecs[i]) begin
            nMode = vecs[i].nm;
            nTrip = vecs[i].nt;
            tick();
            chk($sformatf("vec%0d mode", i), int'(mode), vecs[i].e_mode);
            chk($sformatf("vec%0d mode_change", i), int'(mode_change), int'(vecs[i].e_mc));
            chk($sformatf("vec%0d trip_run", i), int'(trip_run), int'(vecs[i].e_run));
            chk($sformatf("vec%0d trip_clear", i), int'(trip_clear), int'(vecs[i].e_clr));
        end

        // Remaining presses walk the mode through its wrap back to 0
        for (int m = 2; m <= NumModes; m++) mode_press(m % NumModes);

        // Long press with trip_run=1: press debounced at tick 4, clear 16 edges later
        clears = 0; clear_at = -1;
        nTrip = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (trip_clear) begin clears++; clear_at = k; end
            if (k == 19) chk("long run before clear", int'(trip_run), 1);
        end
        chk("long clear count", clears, 1);
        chk("long clear tick", clear_at, 20);
        chk("long run after clear", int'(trip_run), 0);
        nTrip = 1'b1;
        clears = 0; run_changes = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (trip_clear) clears++;
            if (trip_run) run_changes++;
        end
        chk("long release no clear", clears, 0);
        chk("long release no toggle", run_changes, 0);

        trip_short(1'b1);
        trip_short(1'b0);
        trip_short(1'b1);
        mode_press(1);

        // Reset while Trip is held at hold count 10, button released during reset
        nTrip = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        HRESETn = 1'b0;
        #1;
        chk("midreset mode", int'(mode), 0);
        chk("midreset mode_change", int'(mode_change), 0);
        chk("midreset trip_run", int'(trip_run), 0);
        chk("midreset trip_clear", int'(trip_clear), 0);
        nTrip = 1'b1;
        #10;
        HRESETn = 1'b1;
        clears = 0; run_changes = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (trip_clear) clears++;
            if (trip_run) run_changes++;
        end
        chk("post-reset no clear", clears, 0);
        chk("post-reset no toggle", run_changes, 0);
        chk("post-reset mode", int'(mode), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
